// File: rtl/spmv_merge_node_pkg.sv
// Shared types for the SpMV reduction network: beat/lane structs and merge FSM states.
package spmv_pkg;

    localparam int IN_W = 32;
    localparam int ID_W = 32;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [IN_W-1:0] val;
    } spmv_beat_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [IN_W-1:0] val;
        logic            valid;
    } spmv_lane_t;

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } merge_state_e;

    function automatic spmv_beat_t lane_beat(spmv_lane_t l);
        spmv_beat_t b;
        b.id  = l.id;
        b.val = l.val;
        return b;
    endfunction

endpackage

// File: rtl/spmv_merge_node_if.sv
// Two-lane network link: lanes a and b share a single ready driven by the consumer.
interface network_if;
    import spmv_pkg::*;

    spmv_lane_t a;
    spmv_lane_t b;
    logic       ready;

    modport master (output a, output b, input ready);
    modport slave  (input a, input b, output ready);

endinterface

// File: rtl/spmv_merge_node_out_reg.sv
// One-entry valid/ready output register; the parent only loads when it is empty or draining.
module spmv_out_reg
    import spmv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  spmv_beat_t load_beat,
    input  logic       out_ready,
    output spmv_beat_t beat,
    output logic       valid
);

    spmv_beat_t beat_q, beat_d;
    logic       valid_q, valid_d;

    // Next contents: a new load replaces the entry, otherwise a transfer empties it.
    always_comb begin
        beat_d  = beat_q;
        valid_d = valid_q;
        if (load) begin
            beat_d  = load_beat;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            valid_q <= valid_d;
        end
    end

    assign beat  = beat_q;
    assign valid = valid_q;

endmodule

// File: rtl/spmv_merge_node.sv
// Two-lane merge/reduce node: sums equal-id pairs, serialises differing ids lowest first.
// Optional macro SPMV_MERGE_COUNT_EN adds the saturating merge_cnt output.
module spmv_merge_node
    import spmv_pkg::*;
#(
    parameter int IN_WIDTH = IN_W,
    parameter int ID_WIDTH = ID_W
) (
    input  logic                clk,
    input  logic                rst,
    network_if.slave            in,
    output logic [ID_WIDTH-1:0] out_id,
    output logic [IN_WIDTH-1:0] out_val,
    output logic                out_valid,
    input  logic                out_ready
`ifdef SPMV_MERGE_COUNT_EN
    ,
    output logic [31:0]         merge_cnt
`endif
);

    merge_state_e state_q, state_d;
    spmv_beat_t   hold_q, hold_d;
    spmv_beat_t   load_beat, ob;
    logic         load, space, accept;

`ifdef SPMV_MERGE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;
`endif

    assign space    = !out_valid || out_ready;
    assign in.ready = !rst && (state_q == PASS) && space;
    assign accept   = in.ready && (in.a.valid || in.b.valid);

    // Next-state and output-register load selection; hold release takes priority over input.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        load      = 1'b0;
        load_beat = hold_q;
`ifdef SPMV_MERGE_COUNT_EN
        cnt_d     = cnt_q;
`endif
        if (state_q == HOLD) begin
            if (space) begin
                load    = 1'b1;
                state_d = PASS;
            end
        end else if (accept) begin
            load = 1'b1;
            if (in.a.valid && in.b.valid) begin
                if (in.a.id == in.b.id) begin
                    load_beat.id  = in.a.id;
                    load_beat.val = in.a.val + in.b.val;
`ifdef SPMV_MERGE_COUNT_EN
                    if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
`endif
                end else if (in.a.id < in.b.id) begin
                    load_beat = lane_beat(in.a);
                    hold_d    = lane_beat(in.b);
                    state_d   = HOLD;
                end else begin
                    load_beat = lane_beat(in.b);
                    hold_d    = lane_beat(in.a);
                    state_d   = HOLD;
                end
            end else if (in.a.valid) begin
                load_beat = lane_beat(in.a);
            end else begin
                load_beat = lane_beat(in.b);
            end
        end
    end

    // State and hold register; reset discards any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PASS;
            hold_q  <= '0;
`ifdef SPMV_MERGE_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
`ifdef SPMV_MERGE_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    spmv_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_beat (load_beat),
        .out_ready (out_ready),
        .beat      (ob),
        .valid     (out_valid)
    );

    assign out_id  = ob.id;
    assign out_val = ob.val;

`ifdef SPMV_MERGE_COUNT_EN
    assign merge_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_spmv_merge_node.sv
// Self-checking bench for spmv_merge_node: vector table, corner sequences, random vs. queue model.
module tb_spmv_merge_node;
    import spmv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] out_id, out_val;
    logic        out_valid, out_ready;
`ifdef SPMV_MERGE_COUNT_EN
    logic [31:0] merge_cnt;
`endif

    int checks = 0;
    int errors = 0;

    network_if nif ();

    spmv_merge_node dut (
        .clk       (clk),
        .rst       (rst),
        .in        (nif),
        .out_id    (out_id),
        .out_val   (out_val),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SPMV_MERGE_COUNT_EN
        ,
        .merge_cnt (merge_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [31:0] aid, input logic [31:0] aval,
                         input logic bv, input logic [31:0] bid, input logic [31:0] bval);
        nif.a = '{id: aid, val: aval, valid: av};
        nif.b = '{id: bid, val: bval, valid: bv};
    endtask

    typedef struct {
        logic        av;
        logic [31:0] aid, aval;
        logic        bv;
        logic [31:0] bid, bval;
        logic [31:0] e0_id, e0_val;
        logic        has2;
        logic [31:0] e1_id, e1_val;
    } vec_t;

    vec_t vecs[6];
    logic [63:0] exp_q[$];

    task automatic model_push();
        logic [31:0] s;
        if (nif.a.valid && nif.b.valid) begin
            if (nif.a.id == nif.b.id) begin
                s = nif.a.val + nif.b.val;
                exp_q.push_back({nif.a.id, s});
            end else if (nif.a.id < nif.b.id) begin
                exp_q.push_back({nif.a.id, nif.a.val});
                exp_q.push_back({nif.b.id, nif.b.val});
            end else begin
                exp_q.push_back({nif.b.id, nif.b.val});
                exp_q.push_back({nif.a.id, nif.a.val});
            end
        end else if (nif.a.valid) begin
            exp_q.push_back({nif.a.id, nif.a.val});
        end else if (nif.b.valid) begin
            exp_q.push_back({nif.b.id, nif.b.val});
        end
    endtask

    // Called 1 time unit after a negedge: values seen here are those the next posedge samples.
    task automatic model_step();
        logic [63:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("rand_unexpected_beat", {out_id, out_val}, 64'hx);
            end else begin
                e = exp_q.pop_front();
                chk("rand_beat", {out_id, out_val}, e);
            end
        end
        if (nif.ready && (nif.a.valid || nif.b.valid)) model_push();
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'd5, 32'd10, 1'b1, 32'd5, 32'd7, 32'd5, 32'd17, 1'b0, 32'd0, 32'd0};
        vecs[1] = '{1'b1, 32'd9, 32'd3, 1'b1, 32'd4, 32'd8, 32'd4, 32'd8, 1'b1, 32'd9, 32'd3};
        vecs[2] = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0};
        vecs[3] = '{1'b1, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'd1, 32'd2, 32'd1, 32'd1, 1'b0, 32'd0, 32'd0};
        vecs[4] = '{1'b1, 32'd7, 32'h55, 1'b0, 32'd0, 32'd0, 32'd7, 32'h55, 1'b0, 32'd0, 32'd0};
        vecs[5] = '{1'b1, 32'd3, 32'd1, 1'b1, 32'd6, 32'd2, 32'd3, 32'd1, 1'b1, 32'd6, 32'd2};

        rst = 1'b1;
        out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_id", out_id, 0);
        chk("reset_out_val", out_val, 0);
        chk("reset_in_ready", nif.ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", nif.ready, 1);

        // Table vectors from an idle node with the output always ready.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive(vecs[i].av, vecs[i].aid, vecs[i].aval, vecs[i].bv, vecs[i].bid, vecs[i].bval);
            @(posedge clk); #1;
            drive(0, 0, 0, 0, 0, 0);
            chk($sformatf("vec%0d_valid0", i), out_valid, 1);
            chk($sformatf("vec%0d_beat0", i), {out_id, out_val}, {vecs[i].e0_id, vecs[i].e0_val});
            chk($sformatf("vec%0d_ready0", i), nif.ready, !vecs[i].has2);
`ifdef SPMV_MERGE_COUNT_EN
            if (i == 0) chk("merge_cnt_first", merge_cnt, 1);
`endif
            if (vecs[i].has2) begin
                @(posedge clk); #1;
                chk($sformatf("vec%0d_valid1", i), out_valid, 1);
                chk($sformatf("vec%0d_beat1", i), {out_id, out_val}, {vecs[i].e1_id, vecs[i].e1_val});
                chk($sformatf("vec%0d_ready1", i), nif.ready, 1);
            end
            @(posedge clk); #1;
            chk($sformatf("vec%0d_drained", i), out_valid, 0);
        end

        // Back-pressure: lower-id beat held stable for 5 cycles, then both drain in order.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1, 32'd9, 32'd3, 1, 32'd4, 32'd8);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_beat_stable", {out_valid, out_id, out_val}, {1'b1, 32'd4, 32'd8});
            chk("bp_in_ready_low", nif.ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("bp_release_first", {out_valid, out_id, out_val}, {1'b1, 32'd4, 32'd8});
        @(posedge clk); #1;
        chk("bp_second", {out_valid, out_id, out_val}, {1'b1, 32'd9, 32'd3});
        chk("bp_second_ready", nif.ready, 1);
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 0);

        // Reset while a beat is held: the held beat must never appear.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1, 32'd20, 32'd1, 1, 32'd10, 32'd2);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("midhold_rst_ready", nif.ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midhold_out_valid", out_valid, 0);
        chk("midhold_ready_after", nif.ready, 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("midhold_no_emit", out_valid, 0);
        end

        // Random traffic against the queue model.
        exp_q.delete();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom);
            #1;
            model_step();
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            out_ready = 1'b1;
            drive(0, 0, 0, 0, 0, 0);
            #1;
            model_step();
        end
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_final_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spmv_merge_node.md
# spmv_merge_node

Two-lane merge/reduce stage of the SpMV reduction network. It consumes one `network_if` pair (lanes `a` and `b`, shared `ready`) and produces a single registered output stream. Entries with equal row ids are summed into one beat; entries with different ids are emitted serially, lowest id first. A tree of these nodes collapses per-lane partial products into per-row results.

## Interface
- `IN_WIDTH`, 32, value width of both input lanes and of the output.
- `ID_WIDTH`, 32, row-id width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in`  `network_if.slave`  —  input pair: `in.a` and `in.b`, each `{id, val, valid}`. `in.ready` is driven by this block.
- `out_id`  out  ID_WIDTH  output row id.
- `out_val`  out  IN_WIDTH  output value.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `merge_cnt`  out  32  number of summed pairs. Present only with `SPMV_MERGE_COUNT_EN`.

## Operation
- **Input accept:** `in.ready && (in.a.valid || in.b.valid)`. A lane whose `valid` is low contributes nothing.
- **Output handshake:** a beat transfers on `out_valid && out_ready`. `out_id` and `out_val` stay stable while `out_valid && !out_ready`.
- **Cases on accept:**
  - Only `a` valid: emit `a`.
  - Only `b` valid: emit `b`.
  - Both valid, `a.id == b.id`: emit `{a.id, a.val + b.val}`. The sum is modulo 2^IN_WIDTH and the carry is dropped.
  - Both valid, ids differ: emit the lower-id entry now and load the other into the hold register.
- **States:**
  - `PASS`: hold register empty.
  - `HOLD`: hold register full.
  - `PASS -> HOLD` when a differing-id pair is accepted.
  - `HOLD -> PASS` when the held beat moves into the output register. This happens when the output register is empty, or is draining that cycle.
  - `in.ready = (state == PASS) && (!out_valid || out_ready)`.
- **Output register:** single stage. It loads on accept or on hold release, and clears when its beat transfers with nothing new loading.
- **Ordering:** output ids are non-decreasing within one accepted pair. No ordering is enforced across pairs.
- **Reset:**
  - Clears `out_valid` and the hold-valid flag, and sets state to `PASS`.
  - `in.ready` is 0 during reset and 1 in the first cycle after.
  - `out_id` and `out_val` reset to 0; `merge_cnt` resets to 0.
  - Reset mid-HOLD discards the held beat.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- Throughput:
  - 1 beat per cycle for same-id or single-lane traffic.
  - Differing-id pairs take 2 output cycles. `in.ready` is low for exactly 1 cycle when `out_ready` is held high.
- `in.ready` depends combinationally on `out_ready`. There is no combinational path from `in.*` to `out_*`.
- **Back-pressure:** when `out_ready` is low and `out_valid` is high, `in.ready` is 0 and the held beat stays in place.
- **Simultaneous events:** an output transfer and a new load in the same cycle replace the register contents with no bubble.

## Configuration
- Macro: `SPMV_MERGE_COUNT_EN`.
- **Defined:** adds port `merge_cnt`. It increments by 1 on each accepted equal-id pair and saturates at 0xFFFF_FFFF.
- **Undefined:** the port and counter are absent. Datapath behaviour is identical.

## Structure
- **Package `spmv_pkg`:**
  - `spmv_beat_t`: packed `{id, val}`, parameterised via localparams matching the `IN_WIDTH`/`ID_WIDTH` defaults.
  - State enum `merge_state_e {PASS, HOLD}`.
- **Sub-module `spmv_out_reg`:** one-entry valid/ready output register holding `spmv_beat_t`. It is reused by the other network stages.

## Test plan
- **Equal-id sum:** a = {id 5, val 10}, b = {id 5, val 7}, `out_ready` = 1.
  - Next cycle: `out` = {5, 17}, `out_valid` 1, `in.ready` stays 1.
  - `merge_cnt` = 1 if enabled.
- **Differing ids:** a = {9, 3}, b = {4, 8}, `out_ready` = 1.
  - Cycle+1: `out` = {4, 8}, `in.ready` 0.
  - Cycle+2: `out` = {9, 3}, `in.ready` 1.
- **Single lane:** only `b` valid, {2, 0xFFFF_FFFF} -> `out` = {2, 0xFFFF_FFFF} next cycle.
- **Overflow wrap:** a = {1, 0xFFFF_FFFF}, b = {1, 2} -> `out_val` = 1.
- **Back-pressure:** `out_ready` = 0 for 5 cycles after a differing-id pair.
  - `out` holds the lower-id beat stable and `in.ready` stays 0 throughout.
  - After `out_ready` rises, both beats appear in order.
- **Reset mid-HOLD:** assert `rst` for 1 cycle while in HOLD.
  - `out_valid` = 0 and the held beat is never emitted.
  - `in.ready` = 1 on the cycle after reset.
